key_event_decoder: RTL
======================

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 SHALL have parameter LONG_CYC, default 100, meaning consecutive high samples of btn_level that declare a long press (legal range 2..65535).
REQ-002 SHALL have parameter GAP_CYC, default 40, meaning consecutive low samples after a first release that close the double-press window (legal range 2..65535).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port btn_level, input, 1 bit: debounced, clk-synchronous button level, active high.
REQ-006 SHALL have port short_press, output, 1 bit: one-cycle pulse for a single short press.
REQ-007 SHALL have port double_press, output, 1 bit: one-cycle pulse for two short presses within the gap window.
REQ-008 SHALL have port long_press, output, 1 bit: one-cycle pulse when a press reaches LONG_CYC.
REQ-009 SHALL have port held, output, 1 bit: level, high while a long press remains held.
REQ-010 SHALL have port busy, output, 1 bit: level, high whenever FSM is not IDLE.
REQ-011 SHALL have port evt_cnt, output, 8 bits: count of emitted events (short, double, long).

Function
REQ-012 SHALL implement FSM states IDLE, PRESS1, GAP, PRESS2, LHELD with one 16-bit sample counter cleared on every state change.
REQ-013 SHALL move IDLE->PRESS1 on the first edge sampling btn_level=1; that sample counts as high sample 1.
REQ-014 SHALL, in PRESS1, move to LHELD and pulse long_press at the edge taking high sample LONG_CYC.
REQ-015 SHALL, in PRESS1, move to GAP on the first low sample before LONG_CYC; that sample counts as low sample 1.
REQ-016 SHALL, in GAP, move to PRESS2 on any high sample taken before low sample GAP_CYC.
REQ-017 SHALL, in GAP, pulse short_press and return to IDLE at the edge taking low sample GAP_CYC.
REQ-018 SHALL, in PRESS2, pulse double_press and return to IDLE at the edge taking the first low sample.
REQ-019 SHALL, in PRESS2, pulse long_press (no double_press) and move to LHELD at the edge taking high sample LONG_CYC.
REQ-020 SHALL, in LHELD, hold held=1 and return to IDLE at the edge taking the first low sample.
REQ-021 SHALL register all outputs so that pulses and level changes appear on the same edge as the FSM transition causing them.
REQ-022 SHALL make every event pulse exactly one cycle wide, with at most one event output high per cycle.
REQ-023 SHALL increment evt_cnt by 1 on each event pulse, wrapping 255->0.
REQ-024 SHALL ignore btn_level changes other than those listed above; a 1-sample press is a valid press.
REQ-025 SHALL return to IDLE from any unencoded state on the next edge without emitting events.

Reset
REQ-026 SHALL, while rst_n=0, force state IDLE, counter 0, evt_cnt 0 and all outputs 0 asynchronously.
REQ-027 SHALL, on reset release with btn_level already high, treat the first high sample as a new press (IDLE->PRESS1).
REQ-028 SHALL discard any in-progress press or gap window on reset; no event SHALL be emitted for it.

Verification (LONG_CYC=100, GAP_CYC=40)
REQ-029 SHALL cover: high 10 samples, then low 40 -> short_press one cycle at low sample 40; evt_cnt=1; busy drops on that edge.
REQ-030 SHALL cover: high 10, low 5, high 10, low -> double_press at first low sample of second press; no short_press; evt_cnt=1.
REQ-031 SHALL cover: high 150 -> long_press at high sample 100; held=1 from that edge through the first low sample; no short/double.
REQ-032 SHALL cover the gap boundary: high 10, low 39, high 5, low -> double_press; high 10, low 40, high 5 -> short_press at low 40, then new PRESS1.
REQ-033 SHALL cover: rst_n pulsed low at high sample 50 of a press, then btn_level low 100 -> all outputs 0, no event, evt_cnt=0.
REQ-034 SHALL cover: 256 short presses -> evt_cnt reads 255 after the 255th and 0 after the 256th.

Source files
------------

// File: rtl/key_event_decoder.sv
// Button event decoder: classifies a debounced level into short, double
// and long presses with a held level, busy flag and event counter.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   btn_level    debounced, clk-synchronous button level (active high)
//   short_press  one-cycle pulse for a single short press
//   double_press one-cycle pulse for two short presses inside the gap window
//   long_press   one-cycle pulse when a press reaches LONG_CYC samples
//   held         level, high while a long press remains held
//   busy         level, high whenever the FSM is not idle
//   evt_cnt      wrapping count of emitted events
module key_event_decoder #(
  parameter int unsigned LONG_CYC = 100,
  parameter int unsigned GAP_CYC  = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_level,
  output logic       short_press,
  output logic       double_press,
  output logic       long_press,
  output logic       held,
  output logic       busy,
  output logic [7:0] evt_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    LHELD  = 3'd4
  } state_e;

  localparam logic [15:0] LONG_C = 16'(LONG_CYC);
  localparam logic [15:0] GAP_C  = 16'(GAP_CYC);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic        short_q, short_d;
  logic        dbl_q, dbl_d;
  logic        long_q, long_d;
  logic        held_q, held_d;
  logic        busy_q, busy_d;
  logic [7:0]  evt_q, evt_d;

  assign cnt_inc = cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    short_d = 1'b0;
    dbl_d   = 1'b0;
    long_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        // The entering sample is already high sample 1.
        if (btn_level) begin
          state_d = PRESS1;
          cnt_d   = 16'd1;
        end
      end
      PRESS1: begin
        if (!btn_level) begin
          state_d = GAP;
          cnt_d   = 16'd1;
        end else if (cnt_inc == LONG_C) begin
          state_d = LHELD;
          cnt_d   = 16'd0;
          long_d  = 1'b1;
        end
      end
      GAP: begin
        if (btn_level) begin
          state_d = PRESS2;
          cnt_d   = 16'd1;
        end else if (cnt_inc == GAP_C) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
          short_d = 1'b1;
        end
      end
      PRESS2: begin
        if (!btn_level) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
          dbl_d   = 1'b1;
        end else if (cnt_inc == LONG_C) begin
          state_d = LHELD;
          cnt_d   = 16'd0;
          long_d  = 1'b1;
        end
      end
      LHELD: begin
        cnt_d = cnt_q;
        if (!btn_level) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase
    held_d = (state_d == LHELD);
    busy_d = (state_d != IDLE);
    evt_d  = evt_q;
    if (short_d || dbl_d || long_d) begin
      evt_d = evt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      short_q <= 1'b0;
      dbl_q   <= 1'b0;
      long_q  <= 1'b0;
      held_q  <= 1'b0;
      busy_q  <= 1'b0;
      evt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
      dbl_q   <= dbl_d;
      long_q  <= long_d;
      held_q  <= held_d;
      busy_q  <= busy_d;
      evt_q   <= evt_d;
    end
  end

  assign short_press  = short_q;
  assign double_press = dbl_q;
  assign long_press   = long_q;
  assign held         = held_q;
  assign busy         = busy_q;
  assign evt_cnt      = evt_q;

endmodule
